// File: rtl/pdl_pkg.sv
// Shared types and sizes for the PDL buffer controller.
package pdl_pkg;

    localparam int PDL_AW = 10;
    localparam int PDL_DW = 32;

    // Encoding 7 is unassigned and decodes as a no-op.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_IRD   = 3'd3,
        OP_IWR   = 3'd4,
        OP_LDPTR = 3'd5,
        OP_LDIDX = 3'd6
    } pdl_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/pdl_ctl_if.sv
// Request/read-return bundle between a PDL requester (master) and pdl_ctl (slave).
// req_op carries a pdl_pkg::pdl_op_t code.
interface pdl_ctl_if
    import pdl_pkg::*;
#(
    parameter int DW = PDL_DW
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [DW-1:0] req_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/pdl_ptr_reg.sv
// AW-bit register with load, increment and decrement; arithmetic wraps modulo 2**AW.
// Load has priority over increment, increment over decrement.
module pdl_ptr_reg #(
    parameter int             AW      = 10,
    parameter logic [AW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    input  logic          ld,
    input  logic [AW-1:0] ld_val,
    output logic [AW-1:0] q
);

    logic [AW-1:0] q_q;
    logic [AW-1:0] q_d;

    // next value: load, step up, step down or hold
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_val;
        end else if (inc) begin
            q_d = q_q + AW'(1);
        end else if (dec) begin
            q_d = q_q - AW'(1);
        end
    end

    // register with async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pdl_ctl.sv
// PDL buffer controller: requester side of the PDL RAM port.
// Build option PDL_BYPASS_EN: when defined, a read that follows a write to the same
// address is forwarded from the held write data instead of stalling the request port.
//
// Hazard FSM
//   state    | meaning
//   ST_IDLE  | normal operation, one op per cycle
//   ST_STALL | request held off one cycle after a write->read hazard (no bypass build)
module pdl_ctl
    import pdl_pkg::*;
#(
    parameter int AW = PDL_AW,
    parameter int DW = PDL_DW
) (
    input  logic          clk,
    input  logic          reset,
    pdl_ctl_if.slave      req_if,
    input  logic          clr_err,
    output logic [AW-1:0] pdla,
    output logic          prp,
    output logic          pwp,
    output logic [DW-1:0] l,
    input  logic [DW-1:0] pdlo,
    output logic [AW-1:0] pdl_ptr,
    output logic [AW-1:0] pdl_idx,
    output logic [AW:0]   depth,
    output logic          ovf,
    output logic          unf
);

`ifdef PDL_BYPASS_EN
    localparam logic BYP_EN = 1'b1;
`else
    localparam logic BYP_EN = 1'b0;
`endif

    localparam logic [AW:0] DEPTH_MAX = {1'b1, {AW{1'b0}}};

    hz_state_t     state_q, state_d;
    logic [AW-1:0] pdla_q, pdla_d;
    logic          prp_q, prp_d;
    logic          pwp_q, pwp_d;
    logic [DW-1:0] l_q, l_d;
    logic [AW:0]   depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          byp_hit_q, byp_hit_d;
    logic [DW-1:0] byp_data_q, byp_data_d;
    logic          rd_pend_q, rd_pend_d;
    logic          byp_pend_q, byp_pend_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          is_push, is_pop, is_ird, is_iwr, is_ldptr, is_ldidx;
    logic          is_rd;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] ptr_inc;
    logic          hazard, stall, req_ready, acc;

    // op decode
    always_comb begin
        is_push  = 1'b0;
        is_pop   = 1'b0;
        is_ird   = 1'b0;
        is_iwr   = 1'b0;
        is_ldptr = 1'b0;
        is_ldidx = 1'b0;
        case (req_if.req_op)
            OP_PUSH:  is_push  = 1'b1;
            OP_POP:   is_pop   = 1'b1;
            OP_IRD:   is_ird   = 1'b1;
            OP_IWR:   is_iwr   = 1'b1;
            OP_LDPTR: is_ldptr = 1'b1;
            OP_LDIDX: is_ldidx = 1'b1;
            default:  ;
        endcase
    end

    // A write strobe in flight (pwp_q) means the previous edge accepted a write to pdla_q.
    assign is_rd     = is_pop | is_ird;
    assign rd_addr   = is_pop ? pdl_ptr : pdl_idx;
    assign ptr_inc   = pdl_ptr + AW'(1);
    assign hazard    = req_if.req_valid & is_rd & pwp_q & (rd_addr == pdla_q);
    assign stall     = ~BYP_EN & (state_q == ST_IDLE) & hazard;
    assign req_ready = reset & ~stall;
    assign acc       = req_if.req_valid & req_ready;

    // hazard FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (stall) state_d = ST_STALL;
            ST_STALL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // RAM strobes, address and write data for the accepted op
    always_comb begin
        pdla_d = pdla_q;
        l_d    = l_q;
        prp_d  = 1'b0;
        pwp_d  = 1'b0;
        if (acc) begin
            if (is_push) begin
                pdla_d = ptr_inc;
                pwp_d  = 1'b1;
                l_d    = req_if.req_data;
            end
            if (is_iwr) begin
                pdla_d = pdl_idx;
                pwp_d  = 1'b1;
                l_d    = req_if.req_data;
            end
            if (is_rd) begin
                pdla_d = rd_addr;
                prp_d  = 1'b1;
            end
        end
    end

    // depth tracking and sticky error flags; a new event beats clr_err
    always_comb begin
        logic ovf_evt;
        logic unf_evt;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        depth_d = depth_q;
        if (acc) begin
            if (is_push) begin
                if (depth_q == DEPTH_MAX) ovf_evt = 1'b1;
                else                      depth_d = depth_q + (AW+1)'(1);
            end
            if (is_pop) begin
                if (depth_q == '0) unf_evt = 1'b1;
                else               depth_d = depth_q - (AW+1)'(1);
            end
            if (is_ldptr) begin
                depth_d = {1'b0, req_if.req_data[AW-1:0]} + (AW+1)'(1);
            end
        end
        ovf_d = (ovf_q & ~clr_err) | ovf_evt;
        unf_d = (unf_q & ~clr_err) | unf_evt;
    end

    // read-return pipe: strobe -> RAM data cycle -> registered result
    always_comb begin
        byp_hit_d  = BYP_EN & acc & hazard;
        byp_data_d = byp_hit_d ? l_q : byp_data_q;
        rd_pend_d  = prp_q;
        byp_pend_d = byp_hit_q;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_data_q;
        if (rd_pend_q) begin
            rd_data_d = byp_pend_q ? byp_data_q : pdlo;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pdla_q     <= '0;
            prp_q      <= 1'b0;
            pwp_q      <= 1'b0;
            l_q        <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
            rd_pend_q  <= 1'b0;
            byp_pend_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pdla_q     <= pdla_d;
            prp_q      <= prp_d;
            pwp_q      <= pwp_d;
            l_q        <= l_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
            rd_pend_q  <= rd_pend_d;
            byp_pend_q <= byp_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    pdl_ptr_reg #(.AW(AW), .RST_VAL({AW{1'b1}})) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .inc    (acc & is_push),
        .dec    (acc & is_pop),
        .ld     (acc & is_ldptr),
        .ld_val (req_if.req_data[AW-1:0]),
        .q      (pdl_ptr)
    );

    pdl_ptr_reg #(.AW(AW), .RST_VAL('0)) u_idx (
        .clk    (clk),
        .reset  (reset),
        .inc    (1'b0),
        .dec    (1'b0),
        .ld     (acc & is_ldidx),
        .ld_val (req_if.req_data[AW-1:0]),
        .q      (pdl_idx)
    );

    assign req_if.req_ready = req_ready;
    assign req_if.rd_valid  = rd_valid_q;
    assign req_if.rd_data   = rd_data_q;
    assign pdla             = pdla_q;
    assign prp              = prp_q;
    assign pwp              = pwp_q;
    assign l                = l_q;
    assign depth            = depth_q;
    assign ovf              = ovf_q;
    assign unf              = unf_q;

endmodule

// File: tb/tb_pdl_ctl.sv
// Testbench for pdl_ctl: reference model of the stack/index semantics plus RAM and
// read-return scoreboards checked by independent monitors.
module tb_pdl_ctl;
    import pdl_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
`ifdef PDL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clr_err = 1'b0;
    logic [AW-1:0] pdla, pdl_ptr, pdl_idx;
    logic          prp, pwp, ovf, unf;
    logic [DW-1:0] l, pdlo;
    logic [AW:0]   depth;

    pdl_ctl_if #(.DW(DW)) req_if ();

    pdl_ctl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req_if(req_if), .clr_err(clr_err),
        .pdla(pdla), .prp(prp), .pwp(pwp), .l(l), .pdlo(pdlo),
        .pdl_ptr(pdl_ptr), .pdl_idx(pdl_idx), .depth(depth), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // PDL RAM: synchronous read, data valid the cycle after prp
    logic [DW-1:0] ram [1<<AW];
    always @(posedge clk) begin
        if (prp) pdlo <= ram[pdla];
        if (pwp) ram[pdla] = l;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] data; int cyc; } strb_t;
    typedef struct { logic [DW-1:0] data; int cyc; } rd_t;
    strb_t sq[$];
    rd_t   rq[$];

    // reference model
    logic [DW-1:0] m_mem [1<<AW];
    logic [AW-1:0] m_ptr, m_idx, last_wr_addr;
    int            m_depth, last_acc_edge;
    bit            m_ovf, m_unf, last_wr;

    task automatic model_reset();
        m_ptr = '1; m_idx = '0; m_depth = 0; m_ovf = 0; m_unf = 0;
        last_acc_edge = -10; last_wr = 0; last_wr_addr = '0;
    endtask

    task automatic model_accept(input logic [2:0] op, input logic [DW-1:0] d, input bit clr);
        logic [AW-1:0] a;
        bit ov, un;
        int acc;
        acc = cyc + 1;
        a = '0; ov = 0; un = 0;
        case (op)
            3'd1: begin
                a = m_ptr + AW'(1); m_mem[a] = d;
                sq.push_back('{addr:a, wr:1'b1, data:d, cyc:acc});
                m_ptr = a;
                if (m_depth == (1<<AW)) ov = 1; else m_depth++;
            end
            3'd2: begin
                a = m_ptr;
                sq.push_back('{addr:a, wr:1'b0, data:'0, cyc:acc});
                rq.push_back('{data:m_mem[a], cyc:acc+2});
                m_ptr = m_ptr - AW'(1);
                if (m_depth == 0) un = 1; else m_depth--;
            end
            3'd3: begin
                a = m_idx;
                sq.push_back('{addr:a, wr:1'b0, data:'0, cyc:acc});
                rq.push_back('{data:m_mem[a], cyc:acc+2});
            end
            3'd4: begin
                a = m_idx; m_mem[a] = d;
                sq.push_back('{addr:a, wr:1'b1, data:d, cyc:acc});
            end
            3'd5: begin m_ptr = d[AW-1:0]; m_depth = int'(d[AW-1:0]) + 1; end
            3'd6: m_idx = d[AW-1:0];
            default: ;
        endcase
        m_ovf = (m_ovf & !clr) | ov;
        m_unf = (m_unf & !clr) | un;
        last_acc_edge = acc;
        last_wr = (op == 3'd1) || (op == 3'd4);
        last_wr_addr = a;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ptr"}, pdl_ptr, m_ptr);
        chk({tag, "_idx"}, pdl_idx, m_idx);
        chk({tag, "_depth"}, depth, m_depth);
        chk({tag, "_ovf"}, ovf, m_ovf);
        chk({tag, "_unf"}, unf, m_unf);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_op(input logic [2:0] op, input logic [DW-1:0] d, input bit clr);
        int stalls;
        bit hz, got;
        logic [AW-1:0] ra;
        ra = (op == 3'd2) ? m_ptr : m_idx;
        hz = ((op == 3'd2) || (op == 3'd3)) && last_wr && (last_acc_edge == cyc) && (ra == last_wr_addr);
        req_if.req_valid = 1'b1;
        req_if.req_op    = op;
        req_if.req_data  = d;
        clr_err          = clr;
        stalls = 0; got = 0;
        while (!got && stalls <= 4) begin
            @(negedge clk);
            if (req_if.req_ready) got = 1;
            else begin
                stalls++;
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            chk("req_ready_timeout", req_if.req_ready, 1);
            req_if.req_valid = 1'b0; clr_err = 1'b0;
            return;
        end
        model_accept(op, d, clr);
        @(posedge clk); #1;
        req_if.req_valid = 1'b0;
        clr_err = 1'b0;
        chk("stall_cycles", stalls, (hz && !BYP) ? 1 : 0);
        check_state("op");
    endtask

    task automatic do_idle(input int n, input bit clr);
        req_if.req_valid = 1'b0;
        clr_err = clr;
        repeat (n) begin @(posedge clk); #1; end
        clr_err = 1'b0;
        if (clr) begin m_ovf = 0; m_unf = 0; end
        last_wr = 0;
        check_state("idle");
    endtask

    // RAM strobe and read-return monitors
    always @(negedge clk) begin
        strb_t s;
        rd_t   r;
        if (reset) begin
            if (prp || pwp) begin
                if (sq.size() == 0) chk("strobe_unexpected", {prp, pwp}, 2'b00);
                else begin
                    s = sq.pop_front();
                    chk("strobe_kind", {prp, pwp}, s.wr ? 2'b01 : 2'b10);
                    chk("strobe_addr", pdla, s.addr);
                    if (s.wr) chk("strobe_wdata", l, s.data);
                    chk("strobe_cycle", cyc, s.cyc);
                end
            end
            if (req_if.rd_valid) begin
                rv_cnt++;
                if (rq.size() == 0) chk("rd_valid_unexpected", req_if.rd_valid, 1'b0);
                else begin
                    r = rq.pop_front();
                    chk("rd_data", req_if.rd_data, r.data);
                    chk("rd_cycle", cyc, r.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int base;
        logic [2:0] op;
        logic [DW-1:0] d;
        for (int i = 0; i < (1<<AW); i++) begin ram[i] = '0; m_mem[i] = '0; end
        req_if.req_valid = 1'b0;
        req_if.req_op    = 3'd0;
        req_if.req_data  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_if.req_ready, 0);
        chk("rst_pdla", pdla, 0);
        chk("rst_prp", prp, 0);
        chk("rst_pwp", pwp, 0);
        chk("rst_l", l, 0);
        chk("rst_rd_valid", req_if.rd_valid, 0);
        chk("rst_rd_data", req_if.rd_data, 0);
        check_state("rst");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // push/pop round trip
        do_op(OP_PUSH, 32'hA5A5_0001, 0);
        do_op(OP_PUSH, 32'h0000_0002, 0);
        do_op(OP_POP, '0, 0);
        do_op(OP_POP, '0, 0);
        do_idle(3, 0);

        // underflow, clear, and event beating clear
        do_op(OP_POP, '0, 0);
        do_idle(1, 1);
        do_op(OP_POP, '0, 1);
        do_idle(1, 1);

        // overflow at full depth
        do_op(OP_LDPTR, 32'h0000_03FF, 0);
        do_op(OP_PUSH, 32'hDEAD_0003, 0);
        do_op(OP_POP, '0, 0);
        do_idle(1, 1);

        // indexed write then read of the same word
        do_op(OP_LDIDX, 32'd5, 0);
        do_op(OP_IWR, 32'h0000_1234, 0);
        do_op(OP_IRD, '0, 0);
        do_idle(3, 0);

        // back-to-back pushes then pops
        base = rv_cnt;
        for (int i = 0; i < 4; i++) do_op(OP_PUSH, $urandom, 0);
        for (int i = 0; i < 4; i++) do_op(OP_POP, '0, 0);
        do_idle(4, 0);
        chk("lifo_rd_pulses", rv_cnt - base, 4);

        // reset in the cycle after a POP is accepted
        do_op(OP_PUSH, 32'h0BAD_F00D, 0);
        do_op(OP_POP, '0, 0);
        reset = 1'b0;
        #1;
        sq.delete(); rq.delete(); model_reset();
        chk("midrst_prp", prp, 0);
        chk("midrst_rd_valid", req_if.rd_valid, 0);
        chk("midrst_ptr", pdl_ptr, 10'h3FF);
        base = rv_cnt;
        @(negedge clk); @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        do_idle(6, 0);
        chk("midrst_no_rd_after", rv_cnt - base, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_idle($urandom_range(1, 3), $urandom_range(0, 5) == 0);
            end else begin
                op = 3'($urandom_range(0, 7));
                d  = $urandom;
                if (op == 3'd5) begin
                    case ($urandom_range(0, 2))
                        0: d = 32'h0000_03FF;
                        1: d = 32'h0000_0000;
                        default: ;
                    endcase
                end
                do_op(op, d, $urandom_range(0, 15) == 0);
            end
        end
        do_idle(5, 0);
        chk("rd_queue_drained", rq.size(), 0);
        chk("strobe_queue_drained", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
